ahb_slave_interface: RTL and testbench

Upstream AHB-facing stage of the AHB-to-APB bridge; sits directly in front of the APB FSM controller. Qualifies AHB transfers into a combinational `valid`. Pipelines address, write data and direction into the two-deep history (Haddr1/Haddr2, Hwdata1/Hwdata2, Hwritereg) the controller consumes. Decodes the one-hot APB slave select. Owns the AHB two-cycle ERROR response for unmapped or oversize transfers, and merges it with the controller's ready.

---
 rtl/ahb_apb_pkg.sv | 31 +++
 rtl/ahb_slave_interface_if.sv | 38 +++
 rtl/ahb_addr_decode.sv | 28 ++
 rtl/ahb_slave_interface_chk.sv | 24 ++
 rtl/ahb_slave_interface.sv | 147 ++++++++++++++
 tb/tb_ahb_slave_interface.sv | 196 +++++++++++++++++++
 6 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared constants and types for the AHB-to-APB bridge.
// The slave interface, the APB FSM controller and the bench all use this package.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Each APB slave owns one 64 MB region selected by the top address bits.
  localparam logic [31:0] SLV0_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] SLV1_BASE_DEFAULT = 32'h8400_0000;
  localparam logic [31:0] SLV2_BASE_DEFAULT = 32'h8800_0000;
  localparam logic [31:0] SLV_MASK_DEFAULT  = 32'hFC00_0000;

  localparam logic [2:0] HSIZE_MAX = 3'b010;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } err_state_t;

  function automatic logic size_supported(input logic [2:0] hsize);
    return (hsize <= HSIZE_MAX);
  endfunction

endpackage

// File: rtl/ahb_slave_interface_if.sv
// AHB-side and controller-side signals of the bridge's slave interface.
interface ahb_slave_interface_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [1:0]        Htrans;
  logic              Hreadyin;
  logic              Hwrite;
  logic [2:0]        Hsize;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Hready_apb;
  logic              valid;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata1;
  logic [DATA_W-1:0] Hwdata2;
  logic              Hwritereg;
  logic [2:0]        tempselx;
  logic              Hreadyout;
  logic              Hresp;
  logic [DATA_W-1:0] Hrdata;

  modport master (
    output Htrans, Hreadyin, Hwrite, Hsize, Haddr, Hwdata, Prdata, Hready_apb,
    input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
           Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Htrans, Hreadyin, Hwrite, Hsize, Haddr, Hwdata, Prdata, Hready_apb,
    output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
           Hreadyout, Hresp, Hrdata
  );

endinterface

// File: rtl/ahb_addr_decode.sv
// Combinational APB region decode: one-hot select, hit flag and size check.
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] SLV0_BASE = SLV0_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] SLV1_BASE = SLV1_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] SLV2_BASE = SLV2_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] SLV_MASK  = SLV_MASK_DEFAULT
) (
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  output logic              hit,
  output logic [2:0]        sel,
  output logic              size_ok
);

  logic [ADDR_W-1:0] masked_s;

  // Masked compare only, so addresses near the top of the map never alias a region.
  always_comb begin
    masked_s = haddr & SLV_MASK;
    sel      = {(masked_s == SLV2_BASE), (masked_s == SLV1_BASE), (masked_s == SLV0_BASE)};
    hit      = |sel;
    size_ok  = size_supported(hsize);
  end

endmodule

// File: rtl/ahb_slave_interface_chk.sv
// Protocol and consistency checks for the AHB slave interface.
module ahb_slave_interface_chk
  import ahb_apb_pkg::*;
(
  input logic       Hclk,
  input logic       Hreset,
  input logic       Hreadyin,
  input logic       bad,
  input logic       valid,
  input logic       Hreadyout,
  input logic       Hresp,
  input err_state_t err_state
);

  a_no_bad_while_stalled : assert property (@(posedge Hclk) disable iff (Hreset)
    !(bad && !Hreadyin));

  a_err1_response : assert property (@(posedge Hclk) disable iff (Hreset)
    (err_state == ERR1) |-> (!Hreadyout && Hresp));

  a_valid_only_okay : assert property (@(posedge Hclk) disable iff (Hreset)
    valid |-> (err_state == OKAY));

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB-facing front end of the AHB-to-APB bridge: transfer qualification, address/data
// history for the APB controller, slave select, and the two-cycle ERROR response.
module ahb_slave_interface
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SLV0_BASE = SLV0_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] SLV1_BASE = SLV1_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] SLV2_BASE = SLV2_BASE_DEFAULT,
  parameter logic [ADDR_W-1:0] SLV_MASK  = SLV_MASK_DEFAULT
) (
  input logic             Hclk,
  input logic             Hreset,
  ahb_slave_interface_if.slave bus
);

  logic              active_s;
  logic              hit_s;
  logic [2:0]        sel_s;
  logic              size_ok_s;
  logic              bad_s;
  logic              valid_s;
  logic              hreadyout_s;
  logic              hresp_s;
  err_state_t        err_state_r;
  err_state_t        err_next_s;
  logic [ADDR_W-1:0] haddr1_r;
  logic [ADDR_W-1:0] haddr2_r;
  logic [DATA_W-1:0] hwdata1_r;
  logic [DATA_W-1:0] hwdata2_r;
  logic              hwritereg_r;
  logic [2:0]        tempselx_r;

  ahb_addr_decode #(
    .ADDR_W   (ADDR_W),
    .SLV0_BASE(SLV0_BASE),
    .SLV1_BASE(SLV1_BASE),
    .SLV2_BASE(SLV2_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .haddr  (bus.Haddr),
    .hsize  (bus.Hsize),
    .hit    (hit_s),
    .sel    (sel_s),
    .size_ok(size_ok_s)
  );

  // Transfer qualification; BUSY and IDLE never count as a transfer.
  always_comb begin
    active_s = bus.Hreadyin & ((bus.Htrans == HTRANS_NONSEQ) | (bus.Htrans == HTRANS_SEQ));
    bad_s    = active_s & (~hit_s | ~size_ok_s);
    valid_s  = active_s & hit_s & size_ok_s & (err_state_r == OKAY);
  end

  // Address, data and direction history consumed by the APB controller.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      haddr1_r    <= {ADDR_W{1'b0}};
      haddr2_r    <= {ADDR_W{1'b0}};
      hwdata1_r   <= {DATA_W{1'b0}};
      hwdata2_r   <= {DATA_W{1'b0}};
      hwritereg_r <= 1'b0;
      tempselx_r  <= 3'b000;
    end else begin
      haddr1_r    <= bus.Haddr;
      haddr2_r    <= haddr1_r;
      hwdata1_r   <= bus.Hwdata;
      hwdata2_r   <= hwdata1_r;
      hwritereg_r <= bus.Hwrite;
      tempselx_r  <= valid_s ? sel_s : 3'b000;
    end
  end

  // Error FSM state register.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      err_state_r <= OKAY;
    end else begin
      err_state_r <= err_next_s;
    end
  end

  // Error FSM next state; ERR1 ignores the bus so a second error can only start from ERR2.
  always_comb begin
    err_next_s = OKAY;
    case (err_state_r)
      OKAY: begin
        if (bad_s) err_next_s = ERR1;
        else       err_next_s = OKAY;
      end
      ERR1: err_next_s = ERR2;
      ERR2: begin
        if (bad_s) err_next_s = ERR1;
        else       err_next_s = OKAY;
      end
      default: err_next_s = OKAY;
    endcase
  end

  // Error FSM outputs merged with the controller's ready.
  always_comb begin
    hreadyout_s = bus.Hready_apb;
    hresp_s     = HRESP_OKAY;
    case (err_state_r)
      OKAY: begin
        hreadyout_s = bus.Hready_apb;
        hresp_s     = HRESP_OKAY;
      end
      ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = HRESP_ERROR;
      end
      ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = HRESP_ERROR;
      end
      default: begin
        hreadyout_s = bus.Hready_apb;
        hresp_s     = HRESP_OKAY;
      end
    endcase
  end

  assign bus.valid     = valid_s;
  assign bus.Haddr1    = haddr1_r;
  assign bus.Haddr2    = haddr2_r;
  assign bus.Hwdata1   = hwdata1_r;
  assign bus.Hwdata2   = hwdata2_r;
  assign bus.Hwritereg = hwritereg_r;
  assign bus.tempselx  = tempselx_r;
  assign bus.Hreadyout = hreadyout_s;
  assign bus.Hresp     = hresp_s;
  assign bus.Hrdata    = bus.Prdata;

  ahb_slave_interface_chk u_chk (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .Hreadyin (bus.Hreadyin),
    .bad      (bad_s),
    .valid    (valid_s),
    .Hreadyout(hreadyout_s),
    .Hresp    (hresp_s),
    .err_state(err_state_r)
  );

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Bench for ahb_slave_interface: directed vector table, reset sequences and a
// randomized run against a region/arithmetic reference model.
module tb_ahb_slave_interface;
  import ahb_apb_pkg::*;

  typedef struct {
    logic [1:0]  tr;
    logic        rdyin;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        rapb;
    logic        e_valid;
    logic        e_rdy;
    logic        e_resp;
    logic [2:0]  e_sel;
    logic [31:0] e_a1;
    logic [31:0] e_a2;
    logic        e_wr;
  } vec_t;

  logic Hclk = 1'b0;
  logic Hreset = 1'b0;
  always #5 Hclk = ~Hclk;

  ahb_slave_interface_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_slave_interface dut (
    .Hclk  (Hclk),
    .Hreset(Hreset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  // reference model state
  logic [31:0] m_a1 = 32'h0, m_a2 = 32'h0, m_wd1 = 32'h0, m_wd2 = 32'h0;
  logic        m_wr = 1'b0;
  logic [2:0]  m_sel = 3'b000;
  int          m_phase = 0;   // 0 = no error, 1 = first error cycle, 2 = second
  bit          m_known = 1'b0;

  vec_t tbl[20];

  // Region number 0..2 by plain arithmetic on the 64 MB windows, -1 if unmapped.
  function automatic int region_of(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'h8C00_0000) return int'((a - 32'h8000_0000) >> 26);
    return -1;
  endfunction

  function automatic vec_t mk(input logic [1:0] tr, input logic rdyin, input logic wr,
                              input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                              input logic rapb, input logic ev, input logic er, input logic eresp,
                              input logic [2:0] esel, input logic [31:0] ea1,
                              input logic [31:0] ea2, input logic ewr);
    vec_t v;
    v.tr = tr; v.rdyin = rdyin; v.wr = wr; v.sz = sz; v.ad = ad; v.wd = wd; v.rapb = rapb;
    v.e_valid = ev; v.e_rdy = er; v.e_resp = eresp; v.e_sel = esel;
    v.e_a1 = ea1; v.e_a2 = ea2; v.e_wr = ewr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One bus cycle: drive, check combinational outputs, clock, advance model, check registers.
  task automatic cycle(input logic rst, input logic [1:0] tr, input logic rdyin, input logic wr,
                       input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] pr, input logic rapb,
                       output logic o_valid, output logic o_rdy, output logic o_resp);
    int  r;
    bit  act, ok, bad, vexp;
    logic exp_rdy;
    Hreset = rst;
    bus.Htrans = tr; bus.Hreadyin = rdyin; bus.Hwrite = wr; bus.Hsize = sz;
    bus.Haddr = ad; bus.Hwdata = wd; bus.Prdata = pr; bus.Hready_apb = rapb;
    #1;
    o_valid = bus.valid; o_rdy = bus.Hreadyout; o_resp = bus.Hresp;
    act  = rdyin && (tr == 2'b10 || tr == 2'b11);
    r    = region_of(ad);
    ok   = (r >= 0) && (sz <= 3'd2);
    bad  = act && !ok;
    vexp = act && ok && (m_phase == 0);
    exp_rdy = (m_phase == 1) ? 1'b0 : ((m_phase == 2) ? 1'b1 : rapb);
    if (m_known) begin
      chk("valid", 32'(bus.valid), 32'(vexp));
      chk("Hresp", 32'(bus.Hresp), 32'(m_phase != 0));
      chk("Hreadyout", 32'(bus.Hreadyout), 32'(exp_rdy));
    end
    chk("Hrdata", bus.Hrdata, pr);
    @(posedge Hclk);
    if (rst) begin
      m_a1 = 32'h0; m_a2 = 32'h0; m_wd1 = 32'h0; m_wd2 = 32'h0;
      m_wr = 1'b0; m_sel = 3'b000; m_phase = 0;
    end else begin
      m_a2 = m_a1; m_a1 = ad; m_wd2 = m_wd1; m_wd1 = wd; m_wr = wr;
      m_sel = vexp ? 3'(1 << r) : 3'b000;
      if (m_phase == 1) m_phase = 2;
      else              m_phase = bad ? 1 : 0;
    end
    m_known = 1'b1;
    #1;
    chk("Haddr1", bus.Haddr1, m_a1);
    chk("Haddr2", bus.Haddr2, m_a2);
    chk("Hwdata1", bus.Hwdata1, m_wd1);
    chk("Hwdata2", bus.Hwdata2, m_wd2);
    chk("Hwritereg", 32'(bus.Hwritereg), 32'(m_wr));
    chk("tempselx", 32'(bus.tempselx), 32'(m_sel));
  endtask

  initial begin
    logic v, rd, rs;
    logic [31:0] ad;
    logic [2:0]  sz;
    logic        rapb;

    tbl[0]  = mk(2'b10,1'b1,1'b1,3'd2,32'h8000_0010,32'h0000_0000,1'b1, 1'b1,1'b1,1'b0,3'b001,32'h8000_0010,32'h0000_0000,1'b1);
    tbl[1]  = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'hDEAD_BEEF,1'b1, 1'b0,1'b1,1'b0,3'b000,32'h0000_0000,32'h8000_0010,1'b0);
    tbl[2]  = mk(2'b10,1'b1,1'b1,3'd2,32'h8400_0000,32'h0000_0000,1'b1, 1'b1,1'b1,1'b0,3'b010,32'h8400_0000,32'h0000_0000,1'b1);
    tbl[3]  = mk(2'b11,1'b1,1'b1,3'd2,32'h8400_0004,32'h1111_1111,1'b1, 1'b1,1'b1,1'b0,3'b010,32'h8400_0004,32'h8400_0000,1'b1);
    tbl[4]  = mk(2'b10,1'b1,1'b0,3'd2,32'h8800_0020,32'h2222_2222,1'b1, 1'b1,1'b1,1'b0,3'b100,32'h8800_0020,32'h8400_0004,1'b0);
    tbl[5]  = mk(2'b10,1'b1,1'b0,3'd2,32'h0000_0100,32'h0000_0000,1'b1, 1'b0,1'b1,1'b0,3'b000,32'h0000_0100,32'h8800_0020,1'b0);
    tbl[6]  = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b1, 1'b0,1'b0,1'b1,3'b000,32'h0000_0000,32'h0000_0100,1'b0);
    tbl[7]  = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b1,3'b000,32'h0000_0000,32'h0000_0000,1'b0);
    tbl[8]  = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b0, 1'b0,1'b0,1'b0,3'b000,32'h0000_0000,32'h0000_0000,1'b0);
    tbl[9]  = mk(2'b10,1'b1,1'b1,3'd3,32'h8000_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b0,3'b000,32'h8000_0000,32'h0000_0000,1'b1);
    tbl[10] = mk(2'b10,1'b1,1'b1,3'd2,32'h8000_0004,32'h0000_0000,1'b1, 1'b0,1'b0,1'b1,3'b000,32'h8000_0004,32'h8000_0000,1'b1);
    tbl[11] = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b1,3'b000,32'h0000_0000,32'h8000_0004,1'b0);
    tbl[12] = mk(2'b01,1'b1,1'b0,3'd2,32'h8000_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b0,3'b000,32'h8000_0000,32'h0000_0000,1'b0);
    tbl[13] = mk(2'b10,1'b0,1'b0,3'd2,32'h8400_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b0,3'b000,32'h8400_0000,32'h8000_0000,1'b0);
    tbl[14] = mk(2'b10,1'b1,1'b0,3'd2,32'hFFFF_FFFC,32'h0000_0000,1'b0, 1'b0,1'b0,1'b0,3'b000,32'hFFFF_FFFC,32'h8400_0000,1'b0);
    tbl[15] = mk(2'b10,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b0, 1'b0,1'b0,1'b1,3'b000,32'h0000_0000,32'hFFFF_FFFC,1'b0);
    tbl[16] = mk(2'b10,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b1,3'b000,32'h0000_0000,32'h0000_0000,1'b0);
    tbl[17] = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b1, 1'b0,1'b0,1'b1,3'b000,32'h0000_0000,32'h0000_0000,1'b0);
    tbl[18] = mk(2'b00,1'b1,1'b0,3'd2,32'h0000_0000,32'h0000_0000,1'b1, 1'b0,1'b1,1'b1,3'b000,32'h0000_0000,32'h0000_0000,1'b0);
    tbl[19] = mk(2'b10,1'b1,1'b1,3'd0,32'h8800_0000,32'h0000_0000,1'b1, 1'b1,1'b1,1'b0,3'b100,32'h8800_0000,32'h0000_0000,1'b1);

    // Reset held three cycles with random bus activity.
    for (int i = 0; i < 3; i++) begin
      rapb = 1'($urandom);
      cycle(1'b1, 2'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
            $urandom, rapb, v, rd, rs);
    end
    chk("rst_tempselx", 32'(bus.tempselx), 32'h0);
    chk("rst_Haddr1", bus.Haddr1, 32'h0);
    chk("rst_Hresp", 32'(bus.Hresp), 32'h0);
    chk("rst_Hreadyout", 32'(bus.Hreadyout), 32'(bus.Hready_apb));

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, tbl[i].tr, tbl[i].rdyin, tbl[i].wr, tbl[i].sz, tbl[i].ad, tbl[i].wd,
            (i == 4) ? 32'h1234_5678 : $urandom, tbl[i].rapb, v, rd, rs);
      chk($sformatf("tbl%0d_valid", i), 32'(v), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_Hreadyout", i), 32'(rd), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_Hresp", i), 32'(rs), 32'(tbl[i].e_resp));
      chk($sformatf("tbl%0d_tempselx", i), 32'(bus.tempselx), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_Haddr1", i), bus.Haddr1, tbl[i].e_a1);
      chk($sformatf("tbl%0d_Haddr2", i), bus.Haddr2, tbl[i].e_a2);
      chk($sformatf("tbl%0d_Hwritereg", i), 32'(bus.Hwritereg), 32'(tbl[i].e_wr));
      if (i == 4) chk("tbl4_Hrdata", bus.Hrdata, 32'h1234_5678);
    end

    // Reset asserted while in the first error cycle.
    cycle(1'b0, 2'b10, 1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'h0, 1'b1, v, rd, rs);
    chk("err1_Hresp", 32'(bus.Hresp), 32'h1);
    chk("err1_Hreadyout", 32'(bus.Hreadyout), 32'h0);
    cycle(1'b1, 2'b00, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b1, v, rd, rs);
    chk("rst_err_Hresp", 32'(bus.Hresp), 32'h0);
    chk("rst_err_Hreadyout", 32'(bus.Hreadyout), 32'h1);

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ad = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 32'h0400_0000
                               + ($urandom & 32'h03FF_FFFC);
        6, 7:             ad = $urandom;
        8:                ad = 32'hFFFF_FFFC;
        default:          ad = 32'h8C00_0000 + ($urandom & 32'h0000_00FC);
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cycle(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0),
            1'($urandom), sz, ad, $urandom, $urandom, 1'($urandom), v, rd, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
